// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: load-use hazard unit for a classic 5-stage pipeline.
// Besides the one-cycle direct load-use check against ID/EX, each register
// has a small down-counter that stays busy for LOAD_EXTRA cycles after a
// load is accepted. This covers slower loads. A memory wait freezes the whole
// pipeline and the scoreboard. A taken branch flushes IF/ID. Cycles in which
// the PC is held are counted in a saturating statistics counter.
module hazard_scoreboard #(
    parameter int ADDR_W     = 5,
    parameter int LOAD_EXTRA = 0,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              idex_valid,
    input  logic              idex_memread,
    input  logic [ADDR_W-1:0] idex_rt,
    input  logic [ADDR_W-1:0] ifid_rs,
    input  logic [ADDR_W-1:0] ifid_rt,
    input  logic              ifid_uses_rt,
    input  logic              branch_taken,
    input  logic              mem_busy,
    input  logic              stat_clr,
    output logic              stall,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_bubble,
    output logic              flush_ifid,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  stall_count
);

    localparam int         NUM_REGS  = 2 ** ADDR_W;
    localparam logic [1:0] RUN       = 2'd0;
    localparam logic [1:0] LOADSTALL = 2'd1;
    localparam logic [1:0] FREEZE    = 2'd2;
    localparam logic [2:0] LOAD_CNT  = 3'(LOAD_EXTRA);

    logic [2:0]          busy_cnt [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic                direct_hazard;
    logic                sb_hazard;
    logic                hazard;
    logic                load_accept;
    logic [1:0]          state_next;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // A load sitting in ID/EX that the IF/ID instruction depends on right now.
    assign direct_hazard = idex_valid && idex_memread && (idex_rt != '0) &&
                           ((idex_rt == ifid_rs) ||
                            (ifid_uses_rt && (idex_rt == ifid_rt)));

    // Dependence on a load that already left ID/EX but is still in flight.
    assign sb_hazard = busy[ifid_rs] || (ifid_uses_rt && busy[ifid_rt]);

    assign hazard = direct_hazard || sb_hazard;

    // A load advances out of ID/EX only when memory is ready and the load
    // is not squashed by a taken branch.
    assign load_accept = idex_valid && idex_memread && (idex_rt != '0) &&
                         !mem_busy && !branch_taken;

    // Busy view of the scoreboard; r0 is never busy.
    always_comb begin
        busy = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy[r] = (busy_cnt[r] != 3'd0);
        end
        busy[0] = 1'b0;
    end

    // Per-register down-counters: reload on acceptance, count down otherwise, hold on freeze.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                busy_cnt[r] <= 3'd0;
            end
        end else if (!mem_busy) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (load_accept && (idex_rt == ADDR_W'(r))) begin
                    busy_cnt[r] <= LOAD_CNT;
                end else if (busy_cnt[r] != 3'd0) begin
                    busy_cnt[r] <= busy_cnt[r] - 3'd1;
                end
            end
        end
    end

    // Mode register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next mode follows what the pipeline is doing this cycle.
    always_comb begin
        state_next = RUN;
        if (mem_busy) begin
            state_next = FREEZE;
        end else if (stall) begin
            state_next = LOADSTALL;
        end
    end

    // Pipeline controls, priority memory wait > branch flush > hazard > normal.
    always_comb begin
        stall       = 1'b0;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        flush_ifid  = 1'b0;
        if (rst) begin
            stall       = 1'b0;
        end else if (mem_busy) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
        end else if (branch_taken) begin
            flush_ifid  = 1'b1;
            idex_bubble = 1'b1;
        end else if (hazard) begin
            stall       = 1'b1;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    // Statistics: count cycles in which the PC was held; clear wins over count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stat_clr) begin
            stall_count <= '0;
        end else if (!pc_write) begin
            stall_count <= sat_inc(stall_count);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: three instances with different LOAD_EXTRA / CNT_W
// share one stimulus stream and are checked every cycle against a
// time-based model. In the model, each register is busy until a
// "progress time" deadline, and that progress time advances only in cycles
// without a memory wait.
`timescale 1ns/1ps
module tb_hazard_scoreboard;

    localparam int ADDR_W = 5;
    localparam int NI     = 3;
    localparam int E0 = 0, E1 = 2, E2 = 5;
    localparam int W0 = 16, W1 = 4, W2 = 8;
    localparam int unsigned EXT [NI] = '{E0, E1, E2};
    localparam int unsigned SAT [NI] = '{(1 << W0) - 1, (1 << W1) - 1, (1 << W2) - 1};

    logic              clk = 1'b0;
    logic              rst;
    logic              idex_valid, idex_memread;
    logic [ADDR_W-1:0] idex_rt, ifid_rs, ifid_rt;
    logic              ifid_uses_rt, branch_taken, mem_busy, stat_clr;

    logic          stall0, pc0, ifw0, bub0, fl0;
    logic          stall1, pc1, ifw1, bub1, fl1;
    logic          stall2, pc2, ifw2, bub2, fl2;
    logic [1:0]    st0, st1, st2;
    logic [W0-1:0] sc0;
    logic [W1-1:0] sc1;
    logic [W2-1:0] sc2;

    // Observed outputs as {stall, pc_write, ifid_write, idex_bubble, flush_ifid}
    logic [4:0]  obs_vec [NI];
    logic [1:0]  obs_st  [NI];
    logic [31:0] obs_sc  [NI];

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    int unsigned ptime   [NI];
    int unsigned free_at [NI][32];
    int unsigned m_sc    [NI];
    logic [1:0]  m_st    [NI];
    bit          last_stall [NI];

    always #5 clk = ~clk;

    hazard_scoreboard #(.ADDR_W(ADDR_W), .LOAD_EXTRA(E0), .CNT_W(W0)) u_dut0 (
        .clk(clk), .rst(rst), .idex_valid(idex_valid), .idex_memread(idex_memread),
        .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .branch_taken(branch_taken), .mem_busy(mem_busy), .stat_clr(stat_clr),
        .stall(stall0), .pc_write(pc0), .ifid_write(ifw0), .idex_bubble(bub0),
        .flush_ifid(fl0), .state(st0), .stall_count(sc0));

    hazard_scoreboard #(.ADDR_W(ADDR_W), .LOAD_EXTRA(E1), .CNT_W(W1)) u_dut1 (
        .clk(clk), .rst(rst), .idex_valid(idex_valid), .idex_memread(idex_memread),
        .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .branch_taken(branch_taken), .mem_busy(mem_busy), .stat_clr(stat_clr),
        .stall(stall1), .pc_write(pc1), .ifid_write(ifw1), .idex_bubble(bub1),
        .flush_ifid(fl1), .state(st1), .stall_count(sc1));

    hazard_scoreboard #(.ADDR_W(ADDR_W), .LOAD_EXTRA(E2), .CNT_W(W2)) u_dut2 (
        .clk(clk), .rst(rst), .idex_valid(idex_valid), .idex_memread(idex_memread),
        .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .branch_taken(branch_taken), .mem_busy(mem_busy), .stat_clr(stat_clr),
        .stall(stall2), .pc_write(pc2), .ifid_write(ifw2), .idex_bubble(bub2),
        .flush_ifid(fl2), .state(st2), .stall_count(sc2));

    assign obs_vec[0] = {stall0, pc0, ifw0, bub0, fl0};
    assign obs_vec[1] = {stall1, pc1, ifw1, bub1, fl1};
    assign obs_vec[2] = {stall2, pc2, ifw2, bub2, fl2};
    assign obs_st[0]  = st0;
    assign obs_st[1]  = st1;
    assign obs_st[2]  = st2;
    assign obs_sc[0]  = 32'(sc0);
    assign obs_sc[1]  = 32'(sc1);
    assign obs_sc[2]  = 32'(sc2);

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_busy(input int i, input logic [ADDR_W-1:0] r);
        return (r != '0) && (ptime[i] < free_at[i][r]);
    endfunction

    // Expected control vector from the current inputs and model scoreboard.
    function automatic logic [4:0] m_outs(input int i);
        bit direct, haz;
        direct = idex_valid && idex_memread && (idex_rt != '0) &&
                 ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
        haz = direct || m_busy(i, ifid_rs) || (ifid_uses_rt && m_busy(i, ifid_rt));
        if (rst)          return 5'b01100;
        if (mem_busy)     return 5'b00000;
        if (branch_taken) return 5'b01111;
        if (haz)          return 5'b10010;
        return 5'b01100;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            for (int r = 0; r < 32; r++) free_at[i][r] = 0;
            m_sc[i] = 0;
            m_st[i] = 2'd0;
        end
    endtask

    // Effect of one rising edge on the model (same inputs as the checked cycle).
    task automatic model_edge();
        logic [4:0] o;
        if (!rst) begin
            for (int i = 0; i < NI; i++) begin
                o = m_outs(i);
                if (mem_busy)  m_st[i] = 2'd2;
                else if (o[4]) m_st[i] = 2'd1;
                else           m_st[i] = 2'd0;
                if (stat_clr)                      m_sc[i] = 0;
                else if (!o[3] && m_sc[i] < SAT[i]) m_sc[i] = m_sc[i] + 1;
                if (!mem_busy) begin
                    if (idex_valid && idex_memread && idex_rt != '0 && !branch_taken)
                        free_at[i][idex_rt] = ptime[i] + 1 + EXT[i];
                    ptime[i] = ptime[i] + 1;
                end
            end
        end
    endtask

    task automatic drive(input bit v, input bit mr, input int rt, input int rs, input int rt2,
                         input bit u, input bit bt, input bit mb, input bit clr);
        idex_valid   = v;
        idex_memread = mr;
        idex_rt      = ADDR_W'(rt);
        ifid_rs      = ADDR_W'(rs);
        ifid_rt      = ADDR_W'(rt2);
        ifid_uses_rt = u;
        branch_taken = bt;
        mem_busy     = mb;
        stat_clr     = clr;
    endtask

    // Check one cycle at the falling edge, then advance past the rising edge.
    task automatic cycle();
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check_val($sformatf("outs_i%0d", i), 32'(obs_vec[i]), 32'(m_outs(i)));
            check_val($sformatf("state_i%0d", i), 32'(obs_st[i]), 32'(m_st[i]));
            check_val($sformatf("scnt_i%0d", i), obs_sc[i], m_sc[i]);
            last_stall[i] = obs_vec[i][4];
        end
        model_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic int rnd_reg();
        case ($urandom_range(0, 5))
            0:       return 0;
            1:       return 1;
            2:       return 2;
            3, 4:    return 8;
            default: return int'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt [NI];
        for (int i = 0; i < NI; i++) ptime[i] = 0;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        cycle();
        // Reset forces outputs even with a hazard on the inputs
        drive(1, 1, 8, 8, 0, 0, 0, 0, 0);
        #1;
        check_val("rst_force_outs", 32'(obs_vec[1]), 32'(5'b01100));
        check_val("rst_state", 32'(obs_st[1]), 0);
        check_val("rst_scnt", obs_sc[1], 0);
        cycle();
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cycle();

        // Load to r8, consumer rs=8: single-cycle stall with LOAD_EXTRA=0
        drive(1, 1, 8, 8, 0, 0, 0, 0, 0);
        #1;
        check_val("ld_rs_outs_i0", 32'(obs_vec[0]), 32'(5'b10010));
        cycle();
        check_val("ld_rs_state_ls", 32'(obs_st[0]), 1);
        drive(0, 0, 0, 8, 0, 0, 0, 0, 0);
        cycle();
        check_val("ld_rs_state_run", 32'(obs_st[0]), 0);
        for (int k = 0; k < 6; k++) cycle();

        // Load to r8, consumer reads rt=8: stall lengths follow LOAD_EXTRA
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cycle();
        for (int i = 0; i < NI; i++) cnt[i] = 0;
        drive(1, 1, 8, 3, 8, 1, 0, 0, 0);
        cycle();
        for (int i = 0; i < NI; i++) cnt[i] += int'(last_stall[i]);
        drive(0, 0, 0, 3, 8, 1, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            cycle();
            for (int i = 0; i < NI; i++) cnt[i] += int'(last_stall[i]);
        end
        check_val("ldrt_stalls_e0", cnt[0], 1);
        check_val("ldrt_stalls_e2", cnt[1], 3);
        check_val("ldrt_stalls_e5", cnt[2], 6);
        check_val("ldrt_scnt_e0", obs_sc[0], 1);
        check_val("ldrt_scnt_e2", obs_sc[1], 3);
        check_val("ldrt_scnt_e5", obs_sc[2], 6);

        // Load to r0 never hazards or marks busy
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check_val("r0_load_outs", 32'(obs_vec[1]), 32'(5'b01100));
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check_val("r0_after_stall", 32'(obs_vec[2][4]), 0);
        cycle();

        // Taken branch overrides a direct hazard and squashes the load
        drive(1, 1, 8, 8, 0, 0, 1, 0, 0);
        #1;
        check_val("br_haz_outs", 32'(obs_vec[1]), 32'(5'b01111));
        cycle();
        drive(0, 0, 0, 8, 0, 0, 0, 0, 0);
        #1;
        check_val("br_no_entry_e2", 32'(obs_vec[1][4]), 0);
        check_val("br_no_entry_e5", 32'(obs_vec[2][4]), 0);
        cycle();

        // Memory wait freezes a pending r8, stalls resume afterwards
        drive(1, 1, 8, 8, 0, 0, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 8, 0, 0, 0, 1, 0);
        for (int k = 0; k < 4; k++) cycle();
        check_val("frz_state", 32'(obs_st[1]), 2);
        drive(0, 0, 0, 8, 0, 0, 0, 0, 0);
        #1;
        check_val("frz_resume_stall", 32'(obs_vec[1][4]), 1);
        cnt[1] = 0;
        for (int k = 0; k < 7; k++) begin
            cycle();
            cnt[1] += int'(last_stall[1]);
        end
        check_val("frz_resume_count", cnt[1], 2);

        // Saturation with CNT_W=4, then clear racing a stall
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cycle();
        drive(1, 1, 8, 8, 0, 0, 0, 0, 0);
        for (int k = 0; k < 20; k++) cycle();
        check_val("sat_scnt_w4", obs_sc[1], 15);
        check_val("sat_scnt_w16", obs_sc[0], 20);
        drive(1, 1, 8, 8, 0, 0, 0, 0, 1);
        cycle();
        check_val("clr_over_inc", obs_sc[1], 0);

        // Asynchronous reset mid-stall
        drive(1, 1, 8, 8, 0, 0, 0, 0, 0);
        cycle();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < NI; i++) begin
            check_val($sformatf("arst_outs_i%0d", i), 32'(obs_vec[i]), 32'(5'b01100));
            check_val($sformatf("arst_state_i%0d", i), 32'(obs_st[i]), 0);
            check_val($sformatf("arst_scnt_i%0d", i), obs_sc[i], 0);
        end
        cycle();
        rst = 1'b0;
        drive(0, 0, 0, 8, 0, 0, 0, 0, 0);
        #1;
        check_val("post_rst_no_busy", 32'(obs_vec[2][4]), 0);
        cycle();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (rst) model_reset();
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), rnd_reg(),
                  rnd_reg(), rnd_reg(), $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0),
                  ($urandom_range(0, 29) == 0));
            cycle();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameters SHALL be: ADDR_W (default 5), register-address width, NUM_REGS = 2**ADDR_W.
REQ-002 Parameters SHALL include LOAD_EXTRA (default 0, range 0..7): extra load-use stall cycles beyond the classic one.
REQ-003 Parameters SHALL include CNT_W (default 16): width of the stall statistics counter.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- idex_valid  in  1  ID/EX holds a live instruction
- idex_memread  in  1  ID/EX instruction is a load
- idex_rt  in  ADDR_W  load destination register
- ifid_rs  in  ADDR_W  IF/ID source register 1
- ifid_rt  in  ADDR_W  IF/ID source register 2
- ifid_uses_rt  in  1  IF/ID instruction reads rt
- branch_taken  in  1  branch resolved taken in EX this cycle
- mem_busy  in  1  data memory not ready; freeze pipeline
- stat_clr  in  1  synchronous clear of stall_count
- stall  out  1  ID stalled by a load-use hazard
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID register write enable
- idex_bubble  out  1  zero control lines into ID/EX
- flush_ifid  out  1  squash IF/ID contents
- state  out  2  registered mode: RUN=0, LOADSTALL=1, FREEZE=2
- stall_count  out  CNT_W  saturating count of cycles with pc_write=0

Function
REQ-006 Register 0 SHALL never cause a hazard and SHALL never be marked busy.
REQ-007 Direct hazard: idex_valid & idex_memread & idex_rt!=0 & (idex_rt==ifid_rs | (ifid_uses_rt & idex_rt==ifid_rt)).
REQ-008 The scoreboard SHALL hold one down-counter per register, 3 bits wide; busy[r] = (cnt[r]!=0).
REQ-009 Load acceptance: idex_valid & idex_memread & idex_rt!=0 & !mem_busy & !branch_taken. Acceptance SHALL load cnt[idex_rt] with LOAD_EXTRA at the next edge.
REQ-010 In every cycle with mem_busy=0, all other nonzero counters SHALL decrement by 1. When mem_busy=1, all counters SHALL hold.
REQ-011 Scoreboard hazard: busy[ifid_rs] | (ifid_uses_rt & busy[ifid_rt]).
REQ-012 With LOAD_EXTRA=0, no counter SHALL ever become nonzero, so behaviour reduces to the direct hazard only.
REQ-013 Priority SHALL be mem_busy > branch_taken > hazard > normal, with all outputs combinational from the current inputs and scoreboard:
- mem_busy: pc_write=0, ifid_write=0, idex_bubble=0, flush_ifid=0, stall=0.
- branch_taken: pc_write=1, ifid_write=1, flush_ifid=1, idex_bubble=1, stall=0.
- hazard: stall=1, pc_write=0, ifid_write=0, idex_bubble=1, flush_ifid=0.
- normal: pc_write=1, ifid_write=1, others 0.
REQ-014 state SHALL register the next-cycle mode: FREEZE if mem_busy, else LOADSTALL if stall, else RUN.
REQ-015 stall_count SHALL increment on each edge where pc_write=0 and saturate at 2**CNT_W-1.
REQ-016 stat_clr SHALL zero stall_count at the edge and take precedence over an increment in the same cycle.
REQ-017 A load accepted while its destination counter is already nonzero SHALL reload that counter to LOAD_EXTRA (no accumulation).

Reset
REQ-018 While rst=1:
- all scoreboard counters SHALL be 0, state=RUN, stall_count=0.
- outputs SHALL be forced to pc_write=1, ifid_write=1, stall=0, idex_bubble=0, flush_ifid=0, regardless of inputs.
REQ-019 Reset asserted mid-stall SHALL clear pending busy bits immediately; the first cycle after deassertion SHALL behave as normal unless a direct hazard is present.

Verification
REQ-020 LOAD_EXTRA=0: load to r8 in ID/EX, IF/ID reads rs=8 -> stall=1, idex_bubble=1, pc_write=0 for exactly 1 cycle, then state=RUN.
REQ-021 LOAD_EXTRA=2: load to r8 accepted, consumer reads rt=8 with ifid_uses_rt=1 -> stall=1 for 3 consecutive cycles, stall_count +3.
REQ-022 Load to r0 with IF/ID rs=0 -> stall=0, no counter set.
REQ-023 Direct hazard and branch_taken=1 in the same cycle -> flush_ifid=1, idex_bubble=1, pc_write=1, stall=0, and no scoreboard entry set.
REQ-024 LOAD_EXTRA=2 with a pending r8, mem_busy=1 for 4 cycles -> state=FREEZE, cnt[8] held; after release, the remaining stall cycles resume.
REQ-025 CNT_W=4, force 20 stall cycles -> stall_count=15. stat_clr together with a stall -> stall_count=0. rst asserted mid-sequence -> all outputs at reset values asynchronously.
